mod_counter: RTL and testbench
==============================

# mod_counter

Parametrised synchronous counter for the backend datapath. It generalises the free-running 8-bit counter with:
- configurable width and terminal value
- up/down direction, enable and parallel load
- three terminal-count modes: wrap, saturate, one-shot
- registered wrap/terminal event flags

It sits beside timers, address generators and event counters wherever a bounded cycle count is needed.

## Interface

Parameters:
- WIDTH, 8, count register width in bits (1–32)
- MAX, 2**WIDTH-1, terminal value; count range is 0..MAX; must satisfy 1 ≤ MAX ≤ 2**WIDTH-1
- MODE, 0, terminal behaviour: 0 = wrap, 1 = saturate, 2 = one-shot

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clock
- enable  input  1  count one step this cycle when high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  load load_value this cycle
- load_value  input  WIDTH  value loaded on load; values > MAX load as MAX
- count  output  WIDTH  registered count value
- event  output  1  registered one-cycle pulse: count crossed or hit a terminal this cycle
- at_max  output  1  combinational, count == MAX
- at_min  output  1  combinational, count == 0
- done  output  1  registered; MODE 2 only, high while halted; constant 0 in MODES 0/1

## Operation

- Priority per edge: reset > load > enable > hold.
- **reset:**
  - count = 0 when up-counting use is intended; reset always clears count to 0.
  - event = 0, done = 0.
  - State = RUN.
- **load:**
  - count = min(load_value, MAX); event = 0.
  - In MODE 2, state returns to RUN and done = 0.
  - load with enable high: the load wins and no step is taken.
- **enable, up = 1:**
  - count < MAX: count + 1.
  - count == MAX, MODE 0: count = 0, event = 1.
  - count == MAX, MODE 1: count stays MAX, event = 1 on every enabled cycle at MAX.
  - count == MAX, MODE 2: count stays MAX, event = 1, state → HALT, done = 1.
- **enable, up = 0:** mirror image.
  - count > 0: count − 1.
  - At 0, MODE 0: count = MAX.
  - At 0, MODE 1: count holds.
  - At 0, MODE 2: count holds and state → HALT.
  - event = 1 in each of the three at-0 cases.
- **MODE 2 FSM:** two states, RUN and HALT.
  - HALT ignores enable: count holds, event = 0 after the halting edge.
  - HALT exits only via load or reset.
- Arithmetic:
  - Increment and decrement are computed at WIDTH+1 bits; the terminal test is equality with MAX or 0, never carry-out.
  - With MAX = 2**WIDTH-1, wrap coincides with natural overflow; the result must be identical.
- enable low: count holds; event = 0.
- Direction may change on any cycle without penalty.

## Timing

- All outputs except at_max and at_min are registered; zero-cycle input-to-state latency (effect visible after the same edge).
- event is high for exactly the cycle following the terminal edge.
- event is never high two cycles in a row in MODE 0 unless MAX = 1 (or the edge cases below).
- at_max and at_min reflect count in the same cycle.
- **Reset mid-operation:** in any mode or state, the next edge gives count = 0, event = 0, done = 0, state RUN.
- **MAX = 1, MODE 0, enable held:** count toggles 0,1,0,…; event pulses on every edge that leaves 1.
- **Simultaneous load + reset:** reset wins.

## Test plan

- WIDTH=8, MAX=255, MODE 0: reset, then enable, up=1 for 300 cycles → count = 44, event seen exactly once (cycle 256), at_max high at cycle 255.
- WIDTH=4, MAX=9, MODE 0, up=0 from reset → sequence 9,8,…,0,9; event high after each 0→9 transition; at_min high one cycle per period.
- WIDTH=4, MAX=9, MODE 1, load 7, up=1 for 5 cycles → 8,9,9,9,9; event high on the last three cycles; then up=0 → 8, event low.
- WIDTH=8, MAX=100, MODE 2, load 98, enable held → 99,100, then halt; done = 1, event single pulse; further enable leaves count = 100; load 5 → count = 5, done = 0, counting resumes.
- load_value = 200 with MAX = 100 → count = 100. load and enable in the same cycle → loaded value, no step.
- Reset asserted mid-count and in HALT, also together with load → count = 0, event = 0, done = 0 the following cycle.

Source files
------------

// File: rtl/mod_counter.sv
// mod_counter: bounded up/down counter with load, wrap/saturate/one-shot terminal modes
module mod_counter #(
  parameter int              WIDTH = 8,
  parameter longint unsigned MAX   = (64'd1 << WIDTH) - 64'd1,
  parameter int              MODE  = 0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_count,
  output logic             o_event,
  output logic             o_at_max,
  output logic             o_at_min,
  output logic             o_done
);
  typedef enum logic {RUN, HALT} state_t;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_count, w_count, w_clamp, w_wrap;
  logic [WIDTH:0]   w_step;
  logic             r_event, w_event, w_term, w_at_max, w_at_min;
  assign w_at_max = r_count == MAX_V;
  assign w_at_min = r_count == '0;
  assign o_count  = r_count;
  assign o_event  = r_event;
  assign o_at_max = w_at_max;
  assign o_at_min = w_at_min;
  assign o_done   = (MODE == 2) && (r_state == HALT);
  // next count, event and run/halt state; the terminal test is equality with the bound, the step is one bit wider
  always_comb begin
    w_step  = i_up ? {1'b0, r_count} + 1'b1 : {1'b0, r_count} - 1'b1;
    w_term  = i_up ? w_at_max : w_at_min;
    w_wrap  = i_up ? '0 : MAX_V;
    w_clamp = i_load_value > MAX_V ? MAX_V : i_load_value;
    w_count = r_count;
    w_event = 1'b0;
    w_state = r_state;
    if (i_load) begin
      w_count = w_clamp;
      w_state = RUN;
    end else if (i_enable && r_state == RUN) begin
      w_count = !w_term ? WIDTH'(w_step) : (MODE == 0 ? w_wrap : r_count);
      w_event = w_term;
      w_state = (MODE == 2 && w_term) ? HALT : RUN;
    end
  end
  // state register with synchronous reset taking priority over everything
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
      r_event <= 1'b0;
      r_state <= RUN;
    end else begin
      r_count <= w_count;
      r_event <= w_event;
      r_state <= w_state;
    end
  end
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: four counter configurations on shared stimulus, checked against directed values and an integer model
module tb_mod_counter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst = 1'b1, en = 1'b0, up = 1'b0, ld = 1'b0;
  logic [7:0] lv = '0;
  logic [3:0] cb, cc;
  logic [7:0] dc[4];
  logic       de[4], dmx[4], dmn[4], dd[4];
  localparam int MX[4]  = '{255, 9, 9, 100};
  localparam int MD[4]  = '{0, 0, 1, 2};
  localparam int MSK[4] = '{255, 15, 15, 255};
  int mc[4];
  bit me[4], mh[4];
  int n_chk = 0, n_fail = 0;

  mod_counter #(.WIDTH(8), .MAX(255), .MODE(0)) u_a (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_up(up), .i_load(ld), .i_load_value(lv),
    .o_count(dc[0]), .o_event(de[0]), .o_at_max(dmx[0]), .o_at_min(dmn[0]), .o_done(dd[0]));
  mod_counter #(.WIDTH(4), .MAX(9), .MODE(0)) u_b (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_up(up), .i_load(ld), .i_load_value(lv[3:0]),
    .o_count(cb), .o_event(de[1]), .o_at_max(dmx[1]), .o_at_min(dmn[1]), .o_done(dd[1]));
  mod_counter #(.WIDTH(4), .MAX(9), .MODE(1)) u_c (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_up(up), .i_load(ld), .i_load_value(lv[3:0]),
    .o_count(cc), .o_event(de[2]), .o_at_max(dmx[2]), .o_at_min(dmn[2]), .o_done(dd[2]));
  mod_counter #(.WIDTH(8), .MAX(100), .MODE(2)) u_d (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_up(up), .i_load(ld), .i_load_value(lv),
    .o_count(dc[3]), .o_event(de[3]), .o_at_max(dmx[3]), .o_at_min(dmn[3]), .o_done(dd[3]));
  assign dc[1] = {4'b0, cb};
  assign dc[2] = {4'b0, cc};

  task automatic tick(input bit r, input bit e, input bit u, input bit l, input logic [7:0] v);
    bit t;
    int lvk;
    rst = r; en = e; up = u; ld = l; lv = v;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      lvk = int'(v) & MSK[k];
      if (r) begin
        mc[k] = 0; me[k] = 0; mh[k] = 0;
      end else if (l) begin
        mc[k] = lvk > MX[k] ? MX[k] : lvk; me[k] = 0; mh[k] = 0;
      end else if (e && !mh[k]) begin
        t = u ? (mc[k] == MX[k]) : (mc[k] == 0);
        me[k] = t;
        if (!t) mc[k] = u ? mc[k] + 1 : mc[k] - 1;
        else if (MD[k] == 0) mc[k] = u ? 0 : MX[k];
        if (t && MD[k] == 2) mh[k] = 1;
      end else me[k] = 0;
    end
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (dc[k] !== 8'd0 || de[k] !== 1'b0 || dd[k] !== 1'b0 || dmn[k] !== 1'b1 || dmx[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: count=%0d event=%b done=%b at_min=%b at_max=%b, want 0 0 0 1 0", k, dc[k], de[k], dd[k], dmn[k], dmx[k]);
      end
    end
  endtask

  task automatic test_up_wrap;
    int ev = 0;
    tick(1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 300; i++) begin
      tick(0, 1, 1, 0, 8'h00);
      if (de[0] === 1'b1) ev++;
      if (i == 255) begin
        n_chk++;
        if (dmx[0] !== 1'b1) begin n_fail++; $display("FAIL up_wrap at_max@255: got %b want 1", dmx[0]); end
      end
      if (i == 256) begin
        n_chk++;
        if (de[0] !== 1'b1 || dc[0] !== 8'd0) begin n_fail++; $display("FAIL up_wrap event@256: event=%b count=%0d want 1 0", de[0], dc[0]); end
      end
    end
    n_chk++;
    if (dc[0] !== 8'd44 || ev != 1) begin
      n_fail++;
      $display("FAIL up_wrap final: count=%0d events=%0d want 44 1", dc[0], ev);
    end
  endtask

  task automatic test_down_wrap;
    int exp;
    tick(1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 25; i++) begin
      tick(0, 1, 0, 0, 8'h00);
      exp = (10 - i % 10) % 10;
      n_chk++;
      if (dc[1] !== 8'(exp) || de[1] !== (exp == 9) || dmn[1] !== (exp == 0)) begin
        n_fail++;
        $display("FAIL down_wrap step %0d: count=%0d event=%b at_min=%b want %0d %b %b", i, dc[1], de[1], dmn[1], exp, exp == 9, exp == 0);
      end
    end
  endtask

  task automatic test_saturate;
    int ec[5] = '{8, 9, 9, 9, 9};
    bit ee[5] = '{0, 0, 1, 1, 1};
    tick(1, 0, 0, 0, 8'h00);
    tick(0, 0, 0, 1, 8'd7);
    n_chk++;
    if (dc[2] !== 8'd7) begin n_fail++; $display("FAIL saturate load: got %0d want 7", dc[2]); end
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 1, 0, 8'h00);
      n_chk++;
      if (dc[2] !== 8'(ec[i]) || de[2] !== ee[i]) begin
        n_fail++;
        $display("FAIL saturate step %0d: count=%0d event=%b want %0d %b", i, dc[2], de[2], ec[i], ee[i]);
      end
    end
    tick(0, 1, 0, 0, 8'h00);
    n_chk++;
    if (dc[2] !== 8'd8 || de[2] !== 1'b0) begin n_fail++; $display("FAIL saturate down: count=%0d event=%b want 8 0", dc[2], de[2]); end
  endtask

  task automatic test_oneshot;
    int ec[5] = '{99, 100, 100, 100, 100};
    bit ee[5] = '{0, 0, 1, 0, 0};
    bit ed[5] = '{0, 0, 1, 1, 1};
    tick(0, 0, 0, 1, 8'd98);
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 1, 0, 8'h00);
      n_chk++;
      if (dc[3] !== 8'(ec[i]) || de[3] !== ee[i] || dd[3] !== ed[i]) begin
        n_fail++;
        $display("FAIL oneshot step %0d: count=%0d event=%b done=%b want %0d %b %b", i, dc[3], de[3], dd[3], ec[i], ee[i], ed[i]);
      end
    end
    tick(0, 0, 0, 1, 8'd5);
    n_chk++;
    if (dc[3] !== 8'd5 || dd[3] !== 1'b0) begin n_fail++; $display("FAIL oneshot reload: count=%0d done=%b want 5 0", dc[3], dd[3]); end
    tick(0, 1, 1, 0, 8'h00);
    n_chk++;
    if (dc[3] !== 8'd6) begin n_fail++; $display("FAIL oneshot resume: got %0d want 6", dc[3]); end
  endtask

  task automatic test_load;
    tick(0, 0, 0, 1, 8'd200);
    n_chk++;
    if (dc[3] !== 8'd100 || dc[0] !== 8'd200 || dc[1] !== 8'd8) begin
      n_fail++;
      $display("FAIL load_clamp: d=%0d a=%0d b=%0d want 100 200 8", dc[3], dc[0], dc[1]);
    end
    tick(0, 1, 1, 1, 8'd50);
    n_chk++;
    if (dc[3] !== 8'd50 || dc[0] !== 8'd50 || de[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL load_enable: d=%0d a=%0d event=%b want 50 50 0", dc[3], dc[0], de[0]);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 0, 8'h00);
    tick(1, 1, 1, 0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (dc[k] !== 8'd0 || de[k] !== 1'b0) begin n_fail++; $display("FAIL reset_mid[%0d]: count=%0d event=%b want 0 0", k, dc[k], de[k]); end
    end
    tick(0, 0, 0, 1, 8'd100);
    tick(0, 1, 1, 0, 8'h00);
    n_chk++;
    if (dd[3] !== 1'b1) begin n_fail++; $display("FAIL reset_halt setup: done=%b want 1", dd[3]); end
    tick(1, 1, 1, 1, 8'd77);
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (dc[k] !== 8'd0 || de[k] !== 1'b0 || dd[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_load[%0d]: count=%0d event=%b done=%b want 0 0 0", k, dc[k], de[k], dd[k]);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
           $urandom_range(7) == 0, 8'($urandom_range(255)));
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (dc[k] !== 8'(mc[k]) || de[k] !== me[k] || dmx[k] !== (mc[k] == MX[k]) ||
            dmn[k] !== (mc[k] == 0) || dd[k] !== mh[k]) begin
          n_fail++;
          $display("FAIL random[%0d] cycle %0d: count=%0d event=%b at_max=%b at_min=%b done=%b want %0d %b %b %b %b",
                   k, i, dc[k], de[k], dmx[k], dmn[k], dd[k], mc[k], me[k], mc[k] == MX[k], mc[k] == 0, mh[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_up_wrap;
    test_down_wrap;
    test_saturate;
    test_oneshot;
    test_load;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
